// File: rtl/fft_peak_detect.sv
// fft_peak_detect: squared-magnitude peak search over the lower half of each FFT frame.
// Build option FFT_PEAK_SKIP_DC_EN excludes bin 0 from the search.
module fft_peak_detect #(
    parameter int LGFFT = 11,
    parameter int IW    = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_ce,
    input  logic [2*IW-1:0]    i_result,
    input  logic               i_sync,
    output logic               o_valid,
    output logic [LGFFT-1:0]   o_peak_bin,
    output logic [2*IW-1:0]    o_peak_mag,
    output logic               o_err
);
    localparam logic [LGFFT-1:0] LAST_BIN = '1;
`ifdef FFT_PEAK_SKIP_DC_EN
    localparam logic [LGFFT-1:0] FIRST_BIN = LGFFT'(1);
`else
    localparam logic [LGFFT-1:0] FIRST_BIN = '0;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 r_state;
    logic [LGFFT-1:0]       r_cnt;

    logic                   w_take;
    logic                   w_early;
    logic                   w_last;
    logic                   w_srch;
    logic [LGFFT-1:0]       w_bin;

    logic                   r1_v, r1_last, r1_err, r1_first, r1_srch;
    logic signed [IW-1:0]   r1_re, r1_im;
    logic [LGFFT-1:0]       r1_bin;

    logic                   r2_v, r2_last, r2_err, r2_first, r2_srch;
    logic [2*IW-1:0]        r2_mag;
    logic [LGFFT-1:0]       r2_bin;

    logic [2*IW-1:0]        r_max;
    logic [LGFFT-1:0]       r_max_bin;
    logic                   r3_last, r3_err;

    logic signed [2*IW-1:0] w_re2, w_im2;
    logic [2*IW-1:0]        w_sum;

    // A sync sample always restarts framing at bin 0, even mid-frame.
    always_comb begin
        w_take  = i_ce && ((r_state == RUN) || i_sync);
        w_early = i_ce && (r_state == RUN) && i_sync && (r_cnt != '0);
        w_bin   = i_sync ? '0 : r_cnt;
        w_last  = (w_bin == LAST_BIN);
`ifdef FFT_PEAK_SKIP_DC_EN
        w_srch  = !w_bin[LGFFT-1] && (w_bin != '0);
`else
        w_srch  = !w_bin[LGFFT-1];
`endif
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r1_v     <= 1'b0;
            r1_last  <= 1'b0;
            r1_err   <= 1'b0;
            r1_first <= 1'b0;
            r1_srch  <= 1'b0;
            r1_re    <= '0;
            r1_im    <= '0;
            r1_bin   <= '0;
        end else begin
            if (w_take) begin
                r_state <= RUN;
                r_cnt   <= w_bin + LGFFT'(1);
            end
            r1_v     <= w_take;
            r1_last  <= w_last;
            r1_err   <= w_early;
            r1_first <= (w_bin == FIRST_BIN);
            r1_srch  <= w_srch;
            r1_re    <= i_result[2*IW-1:IW];
            r1_im    <= i_result[IW-1:0];
            r1_bin   <= w_bin;
        end
    end

    always_comb begin
        w_re2 = (2*IW)'(r1_re) * (2*IW)'(r1_re);
        w_im2 = (2*IW)'(r1_im) * (2*IW)'(r1_im);
        w_sum = $unsigned(w_re2) + $unsigned(w_im2);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r2_v     <= 1'b0;
            r2_last  <= 1'b0;
            r2_err   <= 1'b0;
            r2_first <= 1'b0;
            r2_srch  <= 1'b0;
            r2_mag   <= '0;
            r2_bin   <= '0;
        end else begin
            r2_v     <= r1_v;
            r2_last  <= r1_last;
            r2_err   <= r1_err;
            r2_first <= r1_first;
            r2_srch  <= r1_srch;
            r2_mag   <= w_sum;
            r2_bin   <= r1_bin;
        end
    end

    // Strict compare keeps the lowest bin on ties.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_max      <= '0;
            r_max_bin  <= '0;
            r3_last    <= 1'b0;
            r3_err     <= 1'b0;
            o_valid    <= 1'b0;
            o_err      <= 1'b0;
            o_peak_bin <= '0;
            o_peak_mag <= '0;
        end else begin
            if (r2_v && r2_srch && (r2_first || (r2_mag > r_max))) begin
                r_max     <= r2_mag;
                r_max_bin <= r2_bin;
            end
            r3_last <= r2_v && r2_last;
            r3_err  <= r2_v && r2_err;
            o_valid <= r3_last;
            o_err   <= r3_err;
            if (r3_last) begin
                o_peak_bin <= r_max_bin;
                o_peak_mag <= r_max;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect: random and directed frames against a frame-level argmax model.
// Build with +define+FFT_PEAK_SKIP_DC_EN to cover the DC-skip variant.
module tb_fft_peak_detect;
    localparam int LG   = 11;
    localparam int N    = 2048;
    localparam int MAXC = 100000;
`ifdef FFT_PEAK_SKIP_DC_EN
    localparam int LO = 1;
`else
    localparam int LO = 0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_ce = 1'b0;
    logic [31:0] i_result = '0;
    logic        i_sync = 1'b0;
    logic        o_valid;
    logic [10:0] o_peak_bin;
    logic [31:0] o_peak_mag;
    logic        o_err;

    fft_peak_detect #(.LGFFT(LG), .IW(16)) dut (
        .i_clk(i_clk),
        .i_reset_n(i_reset_n),
        .i_ce(i_ce),
        .i_result(i_result),
        .i_sync(i_sync),
        .o_valid(o_valid),
        .o_peak_bin(o_peak_bin),
        .o_peak_mag(o_peak_mag),
        .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    bit          exp_v[0:MAXC-1];
    bit          exp_e[0:MAXC-1];
    int          exp_bin[0:MAXC-1];
    logic [31:0] exp_mag[0:MAXC-1];

    logic signed [15:0] fr_re[0:N-1];
    logic signed [15:0] fr_im[0:N-1];

    function automatic logic [31:0] magf(int re, int im);
        longint t;
        t = longint'(re) * re + longint'(im) * im;
        return t[31:0];
    endfunction

    // Frame-level model: collect lower-half magnitudes, argmax at frame end.
    bit          m_run = 0;
    int          m_cnt = 0;
    logic [31:0] mags[0:N/2-1];

    always @(posedge i_clk) begin
        int re, im, best;
        cyc = cyc + 1;
        if (!i_reset_n) begin
            m_run = 0;
            m_cnt = 0;
            for (int k = 0; k < 4; k++) begin
                exp_v[cyc+k] = 0;
                exp_e[cyc+k] = 0;
            end
        end else if (i_ce) begin
            re = int'($signed(i_result[31:16]));
            im = int'($signed(i_result[15:0]));
            if (!m_run && i_sync) begin
                m_run = 1;
                m_cnt = 0;
            end
            if (m_run) begin
                if (i_sync) begin
                    if (m_cnt != 0) exp_e[cyc+3] = 1;
                    m_cnt = 0;
                end
                if (m_cnt < N/2) mags[m_cnt] = magf(re, im);
                if (m_cnt == N-1) begin
                    best = LO;
                    for (int b = LO + 1; b < N/2; b++)
                        if (mags[b] > mags[best]) best = b;
                    exp_v[cyc+3]   = 1;
                    exp_bin[cyc+3] = best;
                    exp_mag[cyc+3] = mags[best];
                end
                m_cnt = (m_cnt + 1) % N;
            end
        end
    end

    int          hb = 0;
    logic [31:0] hm = '0;
    int          nv = 0;
    int          ne = 0;
    int          lv_cyc = 0;
    int          lb = 0;
    longint      lm = 0;

    always @(negedge i_clk) begin
        bit ev, ee;
        if (cyc >= 1) begin
            ev = 0;
            ee = 0;
            if (!i_reset_n) begin
                hb = 0;
                hm = '0;
            end else begin
                ev = exp_v[cyc];
                ee = exp_e[cyc];
                if (ev) begin
                    hb = exp_bin[cyc];
                    hm = exp_mag[cyc];
                end
            end
            n_cmp++;
            if (o_valid !== ev || o_err !== ee ||
                o_peak_bin !== hb[10:0] || o_peak_mag !== hm) begin
                n_fail++;
                $display("FAIL cycle %0d v/e/bin/mag got %b/%b/%0d/%h required %b/%b/%0d/%h",
                         cyc, o_valid, o_err, o_peak_bin, o_peak_mag, ev, ee, hb, hm);
            end
            if (i_reset_n && o_valid) begin
                nv++;
                lv_cyc = cyc;
                lb = int'(o_peak_bin);
                lm = longint'(o_peak_mag);
            end
            if (i_reset_n && o_err) ne++;
        end
    end

    task automatic chk(string nm, longint got, longint want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(int n);
        i_ce = 0;
        repeat (n) begin
            i_result = $urandom;
            i_sync = 1'($urandom_range(1));
            tick();
        end
        i_sync = 0;
    endtask

    int acc_cyc = 0;

    task automatic send(bit s, logic [15:0] re, logic [15:0] im, bit gaps);
        if (gaps) begin
            for (int g = 0; g < 8 && $urandom_range(1) == 1; g++) begin
                i_ce = 0;
                i_sync = 1'($urandom_range(1));
                i_result = $urandom;
                tick();
            end
        end
        i_ce = 1;
        i_sync = s;
        i_result = {re, im};
        tick();
        acc_cyc = cyc;
        i_ce = 0;
        i_sync = 0;
    endtask

    task automatic send_frame(int nb, bit sync0, bit gaps);
        for (int b = 0; b < nb; b++)
            send(sync0 && b == 0, fr_re[b], fr_im[b], gaps);
    endtask

    task automatic clear_frame();
        for (int b = 0; b < N; b++) begin
            fr_re[b] = '0;
            fr_im[b] = '0;
        end
    endtask

    task automatic rand_frame(int amp);
        for (int b = 0; b < N; b++) begin
            if (amp >= 32768) begin
                fr_re[b] = 16'($urandom);
                fr_im[b] = 16'($urandom);
            end else begin
                fr_re[b] = 16'(int'($urandom_range(2*amp)) - amp);
                fr_im[b] = 16'(int'($urandom_range(2*amp)) - amp);
            end
        end
    endtask

    task automatic expect_peak(string nm, int nv0, int ne0, int bin, longint mag);
        idle(6);
        chk({nm, " valid count"}, nv - nv0, 1);
        chk({nm, " err count"}, ne - ne0, 0);
        chk({nm, " bin"}, lb, bin);
        chk({nm, " mag"}, lm, mag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv0, ne0, plen;
        repeat (3) tick();
        i_reset_n = 1;
        idle(20);
        chk("reset valid count", nv, 0);
        chk("reset err count", ne, 0);
        chk("reset peak mag", longint'(o_peak_mag), 0);

        clear_frame();
        fr_re[25] = 16'sd300;
        nv0 = nv; ne0 = ne;
        send_frame(N, 1, 0);
        plen = acc_cyc;
        expect_peak("frameA", nv0, ne0, 25, 90000);
        chk("frameA latency", lv_cyc - plen, 3);

        clear_frame();
        fr_re[40] = -16'sd200; fr_im[40] = 16'sd150;
        fr_re[100] = -16'sd200; fr_im[100] = 16'sd150;
        fr_re[1500] = 16'sd1000;
        nv0 = nv; ne0 = ne;
        send_frame(N, 1, 0);
        expect_peak("tie", nv0, ne0, 40, 62500);

        rand_frame(500);
        nv0 = nv; ne0 = ne;
        send_frame(700, 1, 0);
        clear_frame();
        fr_re[3] = -16'sd32768; fr_im[3] = -16'sd32768;
        send_frame(N, 1, 0);
        idle(6);
        chk("early sync err count", ne - ne0, 1);
        chk("early sync valid count", nv - nv0, 1);
        chk("early sync bin", lb, 3);
        chk("early sync mag", lm, 64'h8000_0000);

        clear_frame();
        fr_re[25] = 16'sd300;
        nv0 = nv; ne0 = ne;
        send_frame(N, 1, 1);
        expect_peak("gapped", nv0, ne0, 25, 90000);

        rand_frame(500);
        send_frame(1000, 1, 0);
        i_reset_n = 0;
        idle(3);
        i_reset_n = 1;
        chk("midreset mag cleared", longint'(o_peak_mag), 0);
        rand_frame(100);
        fr_re[77] = 16'sd2000; fr_im[77] = 16'sd0;
        nv0 = nv; ne0 = ne;
        for (int b = 0; b < 100; b++) send(0, fr_re[b], fr_im[b], 0);
        send_frame(N, 1, 0);
        expect_peak("after reset", nv0, ne0, 77, 4000000);

        clear_frame();
        fr_re[0] = 16'sd5000;
        fr_re[9] = 16'sd10;
        nv0 = nv; ne0 = ne;
        send_frame(N, 1, 0);
`ifdef FFT_PEAK_SKIP_DC_EN
        expect_peak("dc", nv0, ne0, 9, 100);
`else
        expect_peak("dc", nv0, ne0, 0, 25000000);
`endif

        clear_frame();
        nv0 = nv; ne0 = ne;
        send_frame(N, 1, 0);
        expect_peak("zero frame", nv0, ne0, LO, 0);

        for (int b = 0; b < N; b++) begin
            fr_re[b] = 16'sd7;
            fr_im[b] = -16'sd7;
        end
        nv0 = nv; ne0 = ne;
        send_frame(N, 0, 0);
        expect_peak("no-sync flat", nv0, ne0, LO, 98);

        for (int f = 0; f < 3; f++) begin
            rand_frame(32768);
            plen = int'($urandom_range(N - 1, 1));
            send_frame(plen, 1, f[0]);
            rand_frame(32768);
            send_frame(N, 1, !f[0]);
            idle(int'($urandom_range(10)));
        end

        idle(8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_peak_detect.md
# fft_peak_detect

Streaming post-processor downstream of `fftmain`: consumes the core's packed complex output (`o_result`) and frame marker (`o_sync`) and computes the squared magnitude of each bin. It tracks the strongest bin in the positive-frequency half of every frame. At frame end it publishes the peak bin index and its magnitude with a one-cycle valid pulse, which feeds the tone/pitch logic.

## Interface
- `LGFFT`, 11, log2 of FFT length N (N = 2048)
- `IW`, 16, width of each real/imag component
- `i_clk` input 1: system clock, same as `fftmain`
- `i_reset_n` input 1: asynchronous, active-low reset
- `i_ce` input 1: input qualifier; `i_result`/`i_sync` are sampled only when high
- `i_result` input 2*IW: FFT bin; [2*IW-1:IW] = signed real, [IW-1:0] = signed imag
- `i_sync` input 1: high with bin 0 of each frame (from `fftmain` `o_sync`)
- `o_valid` output 1: one-cycle pulse; peak outputs updated
- `o_peak_bin` output LGFFT: index of strongest bin, range 0..N/2-1
- `o_peak_mag` output 2*IW: unsigned re²+im² of that bin
- `o_err` output 1: one-cycle pulse; frame aborted by early sync

## Operation
- FSM states: IDLE and RUN. Reset state is IDLE.
- IDLE: every accepted sample (`i_ce`=1) with `i_sync`=0 is discarded. An accepted sample with `i_sync`=1 is bin 0: go to RUN with the bin counter at 0.
- RUN: each accepted sample increments the bin counter (LGFFT bits).
  - Bin N-1 completes the frame. The counter wraps to 0 and the FSM stays in RUN; the next sample is expected to carry sync.
  - Sync on bin 0 is consistent; no action.
  - Sync with counter ≠ 0: `o_err` pulses and the partial frame's running peak is discarded. The sync sample is treated as bin 0 of a new frame.
  - Sync absent at bin 0: tolerated. The counter still defines framing.
- Magnitude: mag = re*re + im*im, computed unsigned 2*IW bits. The worst case is 2·(2^(IW-1))² = 2^(2*IW-1), which fits in 2*IW bits. There is no saturation and no rounding.
- Peak search covers bins 0..N/2-1 only; bins N/2..N-1 are ignored.
  - The first searched bin of a frame loads the running max unconditionally.
  - After that, the running max updates only when mag is strictly greater, so ties keep the lowest bin.
- At frame completion, the running max and its bin are copied to `o_peak_bin`/`o_peak_mag` and `o_valid` pulses. Outputs then hold until the next completed frame.
- `i_ce` low: no state change. Pipeline contents still drain.
- Reset values: `o_valid`=0, `o_err`=0, `o_peak_bin`=0, `o_peak_mag`=0, FSM=IDLE, counter=0, running max=0. Pipeline valid bits are cleared.
- Reset asserted mid-frame discards all frame state immediately. After release, the block waits in IDLE for a sync.

## Timing
- 3-stage pipeline, advanced every clock. A valid bit carries `i_ce`; this is independent of later `i_ce` activity.
  - S1 registers the components, bin index, frame-last and error flags.
  - S2 registers the squared sum.
  - S3 performs the compare/update and registers the outputs.
- Bin N-1 accepted at rising edge k: `o_valid`=1 from edge k+3 to edge k+4, with `o_peak_*` already valid at edge k+3.
- Early sync accepted at edge k: `o_err`=1 from edge k+3 to edge k+4.
- Throughput is one bin per clock with `i_ce` held high. Gaps in `i_ce` of any length are allowed.
- `o_valid` and `o_err` never assert in the same cycle for the same frame. An aborted frame produces no `o_valid`.

## Configuration
- `FFT_PEAK_SKIP_DC_EN`
  - Defined: bin 0 is excluded from the search, so the search range is 1..N/2-1 and bin 1 loads the running max. A frame with all-zero input then reports bin 1, mag 0.
  - Undefined: bin 0 is included, and an all-zero frame reports bin 0, mag 0.

## Test plan
- Reset, then hold `i_ce`=0 for 20 clocks -> all outputs 0, no pulses.
- One frame, sync at bin 0: bin 25 = {16'sd300, 16'sd0}, all other bins 0 -> `o_valid` 3 clocks after bin 2047, `o_peak_bin`=25, `o_peak_mag`=90000.
- Bins 40 and 100 both {-16'sd200, 16'sd150}; bin 1500 = {16'sd1000, 0} -> bin 40, mag 62500. Confirms the tie rule and that the upper half is ignored.
- Sync reasserted at bin 700, then a full frame with bin 3 = {16'sd-32768, 16'sd-32768} -> `o_err` pulse, no `o_valid` for the aborted frame. The next frame reports bin 3, mag 32'h80000000.
- Random `i_ce` gaps (≈50% duty) with the bin-25 frame -> same result as the continuous case; no extra `o_valid`.
- Assert `i_reset_n` low at bin 1000, release, then 100 samples without sync followed by a full synced frame -> those 100 samples are ignored; one `o_valid` with the correct peak.
- With `FFT_PEAK_SKIP_DC_EN` defined: bin 0 = {16'sd5000, 0}, bin 9 = {16'sd10, 0} -> bin 9, mag 100. Without the macro -> bin 0, mag 25000000.
